// File: rtl/std_bram_pkg.sv
// std_bram_pkg
//   Shared types and elaboration helpers for the std_bram block RAM.
//   - state_t    : clear-sweep controller states (IDLE, CLEAR)
//   - lane_count : number of byte-enable lanes in a data word
//   - addr_width : default address width for a given word count (at least 1)
package std_bram_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  function automatic int lane_count(input int data_width, input int lane_width);
    // A zero lane width makes no sense; treat the whole word as one lane.
    if (lane_width <= 0) begin
      return 1;
    end
    return data_width / lane_width;
  endfunction

  function automatic int addr_width(input int words);
    // A single-word memory still needs a one-bit address port.
    if ($clog2(words) > 1) begin
      return $clog2(words);
    end
    return 1;
  endfunction

endpackage

// File: rtl/std_bram_clear_ctrl.sv
// std_bram_clear_ctrl
//   Clear-sweep sequencer for std_bram. Walks every word address from 0 to
//   WORD_SIZE-1, one per cycle, raising a write strobe so the memory loads its
//   clear value. Reset always restarts the sweep at address 0.
//
//   Ports
//     clk      in   clock
//     rst      in   synchronous active-high reset (forces CLEAR, address 0)
//     clr      in   request a sweep; only honoured while IDLE
//     busy     out  sweep in progress
//     clr_adr  out  address being cleared this cycle
//     clr_we   out  clear write strobe
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | memory available to the user ports
//   CLEAR | writing the clear value to word clr_adr, advancing each cycle
module std_bram_clear_ctrl
  import std_bram_pkg::*;
#(
  parameter int WORD_SIZE     = 16,
  parameter int ADDRESS_WIDTH = addr_width(WORD_SIZE)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  output logic                     busy,
  output logic [ADDRESS_WIDTH-1:0] clr_adr,
  output logic                     clr_we
);

  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADR = ADDRESS_WIDTH'(WORD_SIZE - 1);

  state_t                   state;
  state_t                   state_nx;
  logic [ADDRESS_WIDTH-1:0] cnt;
  logic [ADDRESS_WIDTH-1:0] cnt_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (clr) begin
          state_nx = CLEAR;
          cnt_nx   = '0;
        end
      end
      CLEAR: begin
        // A clear request seen here is deliberately ignored: the sweep
        // already in flight finishes without restarting.
        if (cnt == LAST_ADR) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: begin
        state_nx = CLEAR;
        cnt_nx   = '0;
      end
    endcase
  end

  assign busy    = (state == CLEAR);
  assign clr_we  = (state == CLEAR);
  assign clr_adr = cnt;

endmodule

// File: rtl/std_bram.sv
// std_bram
//   Simple dual-port block RAM: port A writes with per-lane byte enables,
//   port B reads with a latency of 1 or 2 cycles. A clear sweep (on reset or
//   on an i_clr pulse) loads INITIAL_VALUE into every word, one word per
//   cycle, during which both user ports are locked out.
//
//   Optional feature: macro STD_BRAM_FORWARD_EN
//     defined   : a read colliding with a same-cycle write to the same address
//                 returns the merged new word (write-first)
//     undefined : the read returns the stored old word (read-first)
//
//   Ports
//     i_clk   in   clock
//     i_rst   in   synchronous active-high reset, starts a clear sweep
//     i_clr   in   one-cycle pulse, starts a clear sweep when idle
//     i_mea   in   port A enable
//     i_wea   in   port A write enable
//     i_bea   in   port A per-lane write enables
//     i_adra  in   port A address
//     i_da    in   port A write data
//     i_meb   in   port B read enable
//     i_adrb  in   port B address
//     o_qb    out  read data, holds between completed reads
//     o_vb    out  read data valid, one cycle per accepted read
//     o_busy  out  clear sweep in progress
module std_bram
  import std_bram_pkg::*;
#(
  parameter int                    WORD_SIZE     = 16,
  parameter int                    ADDRESS_WIDTH = addr_width(WORD_SIZE),
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    LANE_WIDTH    = 8,
  parameter int                    READ_LATENCY  = 1,
  parameter logic [DATA_WIDTH-1:0] INITIAL_VALUE = '0
) (
  input  logic                                         i_clk,
  input  logic                                         i_rst,
  input  logic                                         i_clr,
  input  logic                                         i_mea,
  input  logic                                         i_wea,
  input  logic [lane_count(DATA_WIDTH, LANE_WIDTH)-1:0] i_bea,
  input  logic [ADDRESS_WIDTH-1:0]                     i_adra,
  input  logic [DATA_WIDTH-1:0]                        i_da,
  input  logic                                         i_meb,
  input  logic [ADDRESS_WIDTH-1:0]                     i_adrb,
  output logic [DATA_WIDTH-1:0]                        o_qb,
  output logic                                         o_vb,
  output logic                                         o_busy
);

  localparam int LANES = lane_count(DATA_WIDTH, LANE_WIDTH);
  // One extra bit so the range compare also works when WORD_SIZE is a
  // power of two and every address pattern is in range.
  localparam logic [ADDRESS_WIDTH:0] DEPTH = (ADDRESS_WIDTH + 1)'(WORD_SIZE);

  logic [DATA_WIDTH-1:0] mem [WORD_SIZE];

  logic                     busy;
  logic                     clr_we;
  logic [ADDRESS_WIDTH-1:0] clr_adr;

  logic                  ports_open;
  logic                  wr_in_range;
  logic                  rd_in_range;
  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] old_word_a;
  logic [DATA_WIDTH-1:0] wr_word;
  logic [DATA_WIDTH-1:0] rd_word;

  logic                  v1;
  logic [DATA_WIDTH-1:0] q1;

  std_bram_clear_ctrl #(
    .WORD_SIZE     (WORD_SIZE),
    .ADDRESS_WIDTH (ADDRESS_WIDTH)
  ) u_clear_ctrl (
    .clk     (i_clk),
    .rst     (i_rst),
    .clr     (i_clr),
    .busy    (busy),
    .clr_adr (clr_adr),
    .clr_we  (clr_we)
  );

  // The cycle that accepts i_clr is already treated as part of the clear:
  // user traffic in that cycle is dropped just like during the sweep.
  assign ports_open  = !busy && !i_clr && !i_rst;
  assign wr_in_range = ({1'b0, i_adra} < DEPTH);
  assign rd_in_range = ({1'b0, i_adrb} < DEPTH);
  assign wr_en       = ports_open && i_mea && i_wea && wr_in_range;
  assign rd_en       = ports_open && i_meb;

  always_comb begin
    old_word_a = INITIAL_VALUE;
    if (wr_in_range) begin
      old_word_a = mem[i_adra];
    end
  end

  // Word as it will look after this cycle's write: enabled lanes from i_da,
  // the rest kept from the stored word.
  always_comb begin
    wr_word = old_word_a;
    for (int k = 0; k < LANES; k++) begin
      if (i_bea[k]) begin
        wr_word[k*LANE_WIDTH +: LANE_WIDTH] = i_da[k*LANE_WIDTH +: LANE_WIDTH];
      end
    end
  end

  always_comb begin
    rd_word = INITIAL_VALUE;
    if (rd_in_range) begin
      rd_word = mem[i_adrb];
    end
`ifdef STD_BRAM_FORWARD_EN
    if (wr_en && (i_adra == i_adrb)) begin
      rd_word = wr_word;
    end
`endif
  end

  // The sweep and the user write never overlap (ports are closed while
  // busy), so one write port into the array is enough.
  always_ff @(posedge i_clk) begin
    if (clr_we) begin
      mem[clr_adr] <= INITIAL_VALUE;
    end else if (wr_en) begin
      mem[i_adra] <= wr_word;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      v1 <= 1'b0;
      q1 <= INITIAL_VALUE;
    end else begin
      v1 <= rd_en;
      if (rd_en) begin
        q1 <= rd_word;
      end
    end
  end

  generate
    if (READ_LATENCY >= 2) begin : g_lat2
      logic                  v2;
      logic [DATA_WIDTH-1:0] q2;

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          v2 <= 1'b0;
          q2 <= INITIAL_VALUE;
        end else begin
          v2 <= v1;
          if (v1) begin
            q2 <= q1;
          end
        end
      end

      assign o_qb = q2;
      assign o_vb = v2;
    end else begin : g_lat1
      assign o_qb = q1;
      assign o_vb = v1;
    end
  endgenerate

  assign o_busy = busy;

endmodule
